// File: rtl/ysyx_040066_mem_arbiter_if.sv
// ysyx_040066_mem_arbiter_if: request/response bundle for N memory requesters.
// The arbiter uses an N-wide copy on the cache side and a 1-wide copy on the memory side.
interface ysyx_040066_mem_arbiter_if #(
    parameter int N      = 1,
    parameter int ADDR_W = 64,
    parameter int DATA_W = 512
);
    logic [N-1:0]        req, we, burst, ready, err;
    logic [3*N-1:0]      len;
    logic [8*N-1:0]      mask;
    logic [ADDR_W*N-1:0] addr;
    logic [DATA_W*N-1:0] wdata;
    logic [DATA_W-1:0]   rdata;
    modport master (output req, we, burst, len, mask, addr, wdata, input ready, err, rdata);
    modport slave  (input req, we, burst, len, mask, addr, wdata, output ready, err, rdata);
endinterface

// File: rtl/ysyx_040066_mem_arbiter.sv
// ysyx_040066_mem_arbiter: round-robin merge of NUM_CH cache channels onto one memory port,
// with registered request fields and a per-transaction response timeout.
module ysyx_040066_mem_arbiter #(
    parameter int NUM_CH  = 3,
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 512,
    parameter int TIMEOUT = 1023
) (
    input  logic clk,
    input  logic rst,
    ysyx_040066_mem_arbiter_if.slave  ch,
    ysyx_040066_mem_arbiter_if.master mem
);
    localparam int GW = $clog2(NUM_CH);
    localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    state_t        state;
    logic [GW-1:0] grant, last_grant, win, k;
    logic [CW-1:0] cnt;
    logic          done, tout;
    assign done = mem.ready[0] | mem.err[0];
    assign tout = TIMEOUT != 0 && cnt == CW'(TIMEOUT);
    // Walk downward so the nearest requester after last_grant overwrites the rest.
    always_comb begin
        win = last_grant;
        k   = last_grant;
        for (int i = NUM_CH; i >= 1; i--) begin
            k = GW'((int'(last_grant) + i) % NUM_CH);
            if (ch.req[k]) win = k;
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= GW'(NUM_CH - 1);
            cnt        <= '0;
            ch.ready   <= '0;
            ch.err     <= '0;
            ch.rdata   <= '0;
            mem.req    <= '0;
            mem.we     <= '0;
            mem.burst  <= '0;
            mem.len    <= '0;
            mem.mask   <= '0;
            mem.addr   <= '0;
            mem.wdata  <= '0;
        end else begin
            case (state)
                IDLE: if (|ch.req) begin
                    grant     <= win;
                    cnt       <= '0;
                    mem.req   <= 1'b1;
                    mem.we    <= ch.we[win];
                    mem.burst <= ch.burst[win];
                    mem.len   <= ch.len[3*win +: 3];
                    mem.mask  <= ch.mask[8*win +: 8];
                    mem.addr  <= ch.addr[ADDR_W*win +: ADDR_W];
                    mem.wdata <= ch.wdata[DATA_W*win +: DATA_W];
                    state     <= BUSY;
                end
                BUSY: if (done || tout) begin
                    // A response in the saturating cycle still wins over the timeout.
                    if (done && !mem.we[0]) ch.rdata <= mem.rdata;
                    ch.ready <= NUM_CH'(1) << grant;
                    ch.err   <= (done && !mem.err[0]) ? '0 : NUM_CH'(1) << grant;
                    mem.req  <= '0;
                    state    <= RESP;
                end else if (cnt != CW'(TIMEOUT)) begin
                    cnt <= cnt + CW'(1);
                end
                RESP: begin
                    ch.ready   <= '0;
                    ch.err     <= '0;
                    last_grant <= grant;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/ysyx_040066_mem_arbiter.md
# ysyx_040066_mem_arbiter

Parametrised N-channel memory-port arbiter that merges the core's independent cache refill/writeback channels (icache refill, dcache read, dcache write, and future DMA/MMU walkers) onto a single downstream memory port. It sits between the `ysyx_040066` cache instances and the SoC bus bridge. It replaces the separate hard-wired `ins_*`, `rd_*` and `wr_*` ports. It adds round-robin fairness, registered request fields, and a per-transaction timeout that returns an error instead of hanging the core.

## Interface
- `NUM_CH`, 3: number of requesting channels, 2..8
- `ADDR_W`, 64: address width
- `DATA_W`, 512: line data width
- `TIMEOUT`, 1023: max cycles waiting for downstream response; 0 disables timeout

- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `ch_req`  in  NUM_CH  per-channel request level, held until its `ch_ready` pulse
- `ch_we`  in  NUM_CH  1 = write, 0 = read
- `ch_burst`  in  NUM_CH  full-line burst when 1, single beat when 0
- `ch_len`  in  3*NUM_CH  single-beat size code, passed through
- `ch_mask`  in  8*NUM_CH  write byte mask, passed through
- `ch_addr`  in  ADDR_W*NUM_CH  request address
- `ch_wdata`  in  DATA_W*NUM_CH  write data
- `ch_ready`  out  NUM_CH  one-cycle completion pulse, one-hot
- `ch_err`  out  NUM_CH  one-cycle error pulse, coincident with `ch_ready`
- `ch_rdata`  out  DATA_W  read data of last completed read, broadcast
- `mem_req`, `mem_we`, `mem_burst`  out  1  downstream request
- `mem_len`  out  3
- `mem_mask`  out  8
- `mem_addr`  out  ADDR_W
- `mem_wdata`  out  DATA_W
- `mem_ready`  in  1  downstream completion, one cycle
- `mem_err`  in  1  downstream error, one cycle; may coincide with `mem_ready`
- `mem_rdata`  in  DATA_W  valid in the cycle `mem_ready` is high

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - If any `ch_req` is high, pick the winner by round-robin.
  - Search starts at `last_grant+1` and wraps modulo NUM_CH.
  - Register all of the winner's fields into the `mem_*` output registers, set `mem_req`, and go to BUSY.
  - With no request, stay in IDLE.
- BUSY:
  - `mem_*` outputs stay constant.
  - On `mem_ready` or `mem_err`: latch the error flag; if `!mem_we`, latch `mem_rdata` into `ch_rdata`. Clear `mem_req` and go to RESP.
  - On timeout (counter reaches TIMEOUT with TIMEOUT≠0): set the error flag, leave `ch_rdata` unchanged, clear `mem_req`, go to RESP.
- RESP:
  - Pulse `ch_ready[grant]`; also pulse `ch_err[grant]` if the error flag is set.
  - Update `last_grant` to `grant`, then go to IDLE.
- `ch_req` is not sampled in BUSY or RESP. A requester that drops `ch_req` mid-flight still gets its pulse, which it ignores.
- `ch_len`/`ch_mask` are only meaningful when burst=0. They pass through unmodified.
- Timeout counter:
  - Width `$clog2(TIMEOUT+1)`.
  - Cleared on entry to BUSY; increments each BUSY cycle; saturates at TIMEOUT.
- Reset (any state, including mid-BUSY): state=IDLE, `last_grant`=NUM_CH-1 so channel 0 wins first.
  - All outputs 0, including `ch_rdata`, `mem_addr` and `mem_wdata`.
  - A downstream transaction in flight is abandoned. The bridge must also be reset.

## Timing
- All outputs are registered; there is no combinational input-to-output path.
- Cycle t: `ch_req[k]` high in IDLE and wins.
- t+1: `mem_req`=1 with channel k's fields.
- `mem_ready` sampled high at cycle r ≥ t+1 → `mem_req`=0 and `ch_ready[k]`=1 at r+1.
- r+2: IDLE, which samples requests again. The requester must drop `ch_req` in cycle r+2 (combinationally on seeing `ch_ready`) or it is re-granted.
- Minimum occupancy is 3 cycles per transaction with zero-latency memory.
- Timeout: with no response, `ch_ready`+`ch_err` pulse at t+TIMEOUT+2.
- `mem_ready` arriving in the same cycle the counter saturates counts as a normal completion; `mem_err` still sets the error flag.
- `mem_ready`/`mem_err` outside BUSY are ignored.
- `ch_rdata` changes only in the RESP-entry edge of a read and is stable thereafter.

## Test plan
- Reset with `ch_req`=3'b111 held and `rst` released → channel 0 granted first, then 1, then 2, then 0. Each `mem_addr` matches its channel (0x8000_0000 / 0x8000_0040 / 0x8000_0080).
- Single read, ch1, addr 0x8000_1000, memory returns 0xA5…A5 after 5 cycles → `mem_req` high 5 cycles, `ch_ready`=3'b010 one cycle later, `ch_rdata`=0xA5…A5, `ch_err`=0.
- Write ch2, burst=0, `mask`=8'h0F, `len`=3'd2, `wdata` low word 0xDEADBEEF → `mem_we`=1, `mem_mask`=8'h0F, `mem_len`=2 held until `mem_ready`; `ch_rdata` unchanged.
- Timeout, TIMEOUT=8, `mem_ready` never asserted → `ch_ready[0]` and `ch_err[0]` pulse exactly 10 cycles after the grant cycle; the next request is served normally.
- `mem_err` and `mem_ready` both high → `ch_ready` and `ch_err` pulse together; a late `mem_ready` in RESP/IDLE is ignored.
- `rst` asserted mid-BUSY (cycle 3 of 10-cycle latency) → all outputs 0 asynchronously. After release, arbitration restarts at channel 0.
